// File: rtl/mpmc_pkg.sv
// mpmc_pkg
// Shared types and helpers for the round-robin multi-port memory controller.
// Holds the controller state encoding, the rw direction constants and a
// one-hot to index conversion used by the arbiter.
package mpmc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        LOW_POWER = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Widest one-hot vector the helper accepts; callers zero-extend.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mpmc_rr_ctrl_if.sv
// mpmc_rr_ctrl_if
// Flattened per-port request bus between the requesters and the controller.
//   req    per-port request level
//   rw     per-port direction, 1=write 0=read
//   addr   port p at [p*ADDR_W +: ADDR_W]
//   wdata  port p at [p*DATA_W +: DATA_W]
//   grant  one-hot pulse, request accepted
//   done   one-hot pulse, access complete
//   rdata  read data, valid with read done and held until the next one
// master: requester side; slave: controller side.
interface mpmc_rr_ctrl_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        rw;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS-1:0]        done;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output req, rw, addr, wdata,
        input  grant, done, rdata
    );

    modport slave (
        input  req, rw, addr, wdata,
        output grant, done, rdata
    );
endinterface

// File: rtl/mpmc_rr_arbiter.sv
// mpmc_rr_arbiter
// Combinational round-robin picker. Searches from the port after 'last'
// (wrapping) and returns the first requesting port, one-hot and as index.
//   req        per-port request level
//   advance    enables a pick; winner is all-zero when low
//   last       index of the most recently granted port
//   winner     one-hot winning port
//   winner_idx index of the winning port
module mpmc_rr_arbiter
    import mpmc_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] winner,
    output logic [IDX_W-1:0]     winner_idx
);

    always_comb begin
        int  p;
        logic found;
        winner = '0;
        found  = 1'b0;
        p      = 0;
        // Offsets 1..NUM_PORTS: the last-granted port is checked last.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            p = (int'(last) + i) % NUM_PORTS;
            if (advance && !found && req[p]) begin
                winner[p] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign winner_idx = IDX_W'(onehot_to_idx(32'(winner)));

endmodule

// File: rtl/mpmc_rr_ctrl.sv
// mpmc_rr_ctrl
// Round-robin multi-port controller in front of one single-port memory.
// One request is arbitrated per IDLE cycle, then held for PROC_CYCLES cycles
// in ACCESS; grant pulses in the first access cycle, done in the last.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus            mpmc_rr_ctrl_if.slave request bus
//   mem_addr/mem_rw/mem_wdata  latched transaction (observability)
//   busy           high in ACCESS
//   low_power      high in LOW_POWER
// Build option: MPMC_LOW_POWER_EN adds the idle timer and LOW_POWER state;
// without it low_power is tied low and IDLE waits indefinitely.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate pending requests, count idle cycles
// ACCESS    | serve latched transaction for PROC_CYCLES cycles
// LOW_POWER | parked after IDLE_TIMEOUT idle cycles; any req wakes to IDLE
module mpmc_rr_ctrl
    import mpmc_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int MEM_DEPTH    = 2**ADDR_W,
    parameter int PROC_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 10
) (
    input  logic               clk,
    input  logic               rst,
    mpmc_rr_ctrl_if.slave      bus,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rw,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               busy,
    output logic               low_power
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROC_CYCLES - 1);

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    mem [MEM_DEPTH];
    logic [NUM_PORTS-1:0] win_oh, cur_oh;
    logic [IDX_W-1:0]     win_idx, last_q;
    logic [CNT_W-1:0]     acc_left;
    logic                 acc_first, acc_last, in_range, rd_done, take;
    logic [DATA_W-1:0]    rd_word, rdata_q;

    mpmc_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req        (bus.req),
        .advance    (state_q == IDLE),
        .last       (last_q),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Access timer counts down from PROC_CYCLES-1; 0 is the final cycle.
    assign acc_first = (acc_left == CNT_LOAD);
    assign acc_last  = (acc_left == '0);
    assign take      = (state_q == IDLE) && (|win_oh);
    assign in_range  = (int'(mem_addr) < MEM_DEPTH);
    assign rd_word   = in_range ? mem[mem_addr] : '0;
    assign rd_done   = (state_q == ACCESS) && acc_last && (mem_rw == RW_READ);

`ifdef MPMC_LOW_POWER_EN
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_left;
    logic              idle_expired;

    assign idle_expired = (idle_left == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_left <= IDLE_LOAD;
        end else if (state_q == IDLE) begin
            if (take || idle_expired) begin
                idle_left <= IDLE_LOAD;
            end else begin
                idle_left <= idle_left - IDLE_W'(1);
            end
        end
    end

    assign low_power = (state_q == LOW_POWER);
`else
    assign low_power = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ACCESS;
                end
`ifdef MPMC_LOW_POWER_EN
                else if (idle_expired) begin
                    state_d = LOW_POWER;
                end
`endif
            end
            ACCESS: begin
                if (acc_last) begin
                    state_d = IDLE;
                end
            end
            LOW_POWER: begin
                // Wake only; arbitration waits for the next IDLE cycle.
                if (|bus.req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_oh    <= '0;
            last_q    <= IDX_W'(NUM_PORTS - 1);
            acc_left  <= '0;
            mem_addr  <= '0;
            mem_rw    <= RW_READ;
            mem_wdata <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (take) begin
                cur_oh    <= win_oh;
                last_q    <= win_idx;
                acc_left  <= CNT_LOAD;
                mem_addr  <= bus.addr[win_idx*ADDR_W +: ADDR_W];
                mem_rw    <= bus.rw[win_idx];
                mem_wdata <= bus.wdata[win_idx*DATA_W +: DATA_W];
            end else if (state_q == ACCESS && !acc_last) begin
                acc_left <= acc_left - CNT_W'(1);
            end
            // Out-of-range writes are dropped silently.
            if (state_q == ACCESS && acc_last && mem_rw == RW_WRITE && in_range) begin
                mem[mem_addr] <= mem_wdata;
            end
            if (rd_done) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign bus.grant = (state_q == ACCESS && acc_first) ? cur_oh : '0;
    assign bus.done  = (state_q == ACCESS && acc_last)  ? cur_oh : '0;
    // Current read result during the done cycle, last read result otherwise.
    assign bus.rdata = rd_done ? rd_word : rdata_q;
    assign busy      = (state_q == ACCESS);

endmodule

// File: tb/tb_mpmc_rr_ctrl.sv
module tb_mpmc_rr_ctrl;
    localparam int NP    = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int PC    = 2;
    localparam int ITO   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpmc_rr_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          low_power;

    mpmc_rr_ctrl #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH),
        .PROC_CYCLES(PC), .IDLE_TIMEOUT(ITO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
        .busy(busy), .low_power(low_power)
    );

    typedef struct {
        int            port;
        bit            wr;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl [16];
    logic [DW-1:0] last_rd;
    int            checks   = 0;
    int            failures = 0;
    int            rr_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input bit wr, input int a, input int d);
        bus.req[p]             = 1'b1;
        bus.rw[p]              = wr;
        bus.addr[p*AW +: AW]   = AW'(a);
        bus.wdata[p*DW +: DW]  = DW'(d);
    endtask

    task automatic push_exp(input int p, input bit wr, input int a, input int d);
        exp_t e;
        e.port = p;
        e.wr   = wr;
        e.rd   = '0;
        if (a < DEPTH) begin
            if (wr) mdl[a] = DW'(d);
            else    e.rd   = mdl[a];
        end
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow_done", 32'(bus.done), 32'(0));
            return;
        end
        e = sb.pop_front();
        chk("done_port", 32'(bus.done), 32'(1) << e.port);
        if (!e.wr) begin
            chk("rdata", 32'(bus.rdata), 32'(e.rd));
            last_rd = e.rd;
        end
    endtask

    // One transaction from an idle (or low-power) controller.
    task automatic xfer(input int p, input bit wr, input int a, input int d, input int glat);
        int n;
        int m;
        push_exp(p, wr, a, d);
        drive(p, wr, a, d);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.grant == '0 && n < 20);
        chk("grant_lat", n, glat);
        chk("grant_oh", 32'(bus.grant), 32'(1) << p);
        bus.req[p] = 1'b0;
        m = 0;
        while (bus.done == '0 && m < 20) begin
            tick();
            m++;
        end
        chk("done_lat", n + m, glat + PC - 1);
        chk("busy_at_done", 32'(busy), 32'(1));
        pop_chk();
        rr_last = p;
        tick();
        if (!wr) chk("rdata_hold", 32'(bus.rdata), 32'(last_rd));
    endtask

    // All ports write continuously; grants must rotate one per PC+1 cycles.
    task automatic rr_burst(input int n_grants, input int salt);
        int got;
        int cyc;
        int since;
        int exp_p;
        got   = 0;
        cyc   = 0;
        since = 0;
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 8 + p, 'h10 + p + salt);
        while ((got < n_grants || sb.size() > 0) && cyc < 80) begin
            tick();
            cyc++;
            since++;
            if (bus.grant != '0) begin
                if (got >= n_grants) begin
                    chk("rr_extra_grant", 32'(bus.grant), 32'(0));
                end else begin
                    exp_p = (rr_last + 1) % NP;
                    chk("rr_grant", 32'(bus.grant), 32'(1) << exp_p);
                    chk("rr_spacing", since, (got == 0) ? 1 : PC + 1);
                    push_exp(exp_p, 1'b1, 8 + exp_p, 'h10 + exp_p + salt);
                    rr_last = exp_p;
                    got++;
                    since = 0;
                    if (got == n_grants) bus.req = '0;
                end
            end
            if (bus.done != '0) pop_chk();
        end
        chk("rr_complete", got, n_grants);
        chk("rr_drained", sb.size(), 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw;
        rst       = 1'b1;
        bus.req   = '0;
        bus.rw    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        rr_last   = NP - 1;
        last_rd   = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick();
        tick();

        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_rdata", 32'(bus.rdata), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_low_power", 32'(low_power), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_rw", 32'(mem_rw), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        rst = 1'b0;

        // Write then read back on port 0.
        xfer(0, 1'b1, 3, 'hA5, 1);
        chk("mem_wdata_latch", 32'(mem_wdata), 32'hA5);
        xfer(0, 1'b0, 3, 0, 1);

        // Round robin from last grant = port 0: 1,2,3,0,1.
        rr_burst(5, 0);
        xfer(2, 1'b0, 10, 0, 1);
        xfer(3, 1'b0, 8, 0, 1);

        // Out-of-range write dropped, read returns 0, neighbours untouched.
        xfer(1, 1'b1, 14, 'h77, 1);
        xfer(1, 1'b0, 14, 0, 1);
        xfer(0, 1'b0, 3, 0, 1);
        xfer(2, 1'b0, 2, 0, 1);

`ifdef MPMC_LOW_POWER_EN
        n = 0;
        while (!low_power && n < 40) begin
            tick();
            n++;
        end
        chk("lp_entry_cycles", n, ITO);
        chk("lp_busy", 32'(busy), 32'(0));
        xfer(2, 1'b0, 3, 0, 2);
        chk("lp_exit", 32'(low_power), 32'(0));
`else
        saw = 1'b0;
        repeat (50) begin
            tick();
            if (low_power !== 1'b0) saw = 1'b1;
        end
        chk("lp_never", 32'(saw), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        xfer(2, 1'b0, 3, 0, 1);
`endif

        // Reset in the middle of a write aborts it.
        drive(1, 1'b1, 5, 'h3C);
        tick();
        chk("abort_grant", 32'(bus.grant), 32'(1) << 1);
        rst     = 1'b1;
        bus.req = '0;
        tick();
        chk("abort_no_done", 32'(bus.done), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        rr_last = NP - 1;
        sb.delete();

        // From reset the rotation starts at port 0: 0,1,2,3,0.
        rr_burst(5, 'h20);
        xfer(1, 1'b0, 5, 0, 1);
        xfer(3, 1'b0, 11, 0, 1);
        xfer(0, 1'b0, 3, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpmc_rr_ctrl.md
# mpmc_rr_ctrl

Parametrised multi-port memory controller that arbitrates N requesters onto one internal single-port memory. It is the next-generation replacement for the two-port fixed-priority controller. It adds round-robin fairness, configurable access latency, flattened per-port buses, explicit completion pulses and a compile-time optional low-power idle mode. It sits between processor-side requesters and on-chip storage.

## Interface
- NUM_PORTS, 4, number of requesters (≥2)
- ADDR_W, 4, address width
- DATA_W, 8, data width
- MEM_DEPTH, 2**ADDR_W, words implemented (≤2**ADDR_W)
- PROC_CYCLES, 2, cycles per access (≥1)
- IDLE_TIMEOUT, 10, idle cycles before low power (≥1)

Clocking and reset are decided: one clock; reset is asynchronous and active-high.

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_PORTS  per-port request level
- rw  in  NUM_PORTS  per-port direction: 1=write, 0=read
- addr  in  NUM_PORTS*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  port p at [p*DATA_W +: DATA_W]
- grant  out  NUM_PORTS  one-hot, 1-cycle pulse: request accepted
- done  out  NUM_PORTS  one-hot, 1-cycle pulse: access complete
- rdata  out  DATA_W  read data, valid with read done, held until the next read done
- mem_addr / mem_rw / mem_wdata  out  ADDR_W/1/DATA_W  latched transaction (observability)
- busy  out  1  high in ACCESS
- low_power  out  1  high in LOW_POWER

## Operation
- States: IDLE, ACCESS, LOW_POWER. Reset state is IDLE. All outputs reset to 0. Memory resets to all-zero. The round-robin pointer resets so port 0 has top priority.
- IDLE, any req: the arbiter picks the first requesting port after the last-granted port (wrapping). The controller latches that port's rw/addr/wdata into mem_* and moves to ACCESS. The idle counter clears.
- IDLE, no req: the idle counter increments. When it reaches IDLE_TIMEOUT, the controller moves to LOW_POWER.
- ACCESS: the access counter runs 1..PROC_CYCLES.
  - grant[winner] pulses in ACCESS cycle 1.
  - done[winner] pulses in cycle PROC_CYCLES.
  - Writes commit to memory at the end of cycle PROC_CYCLES.
  - Reads drive rdata = mem[mem_addr] during cycle PROC_CYCLES.
  - The controller then returns to IDLE.
- LOW_POWER: any req moves the controller to IDLE. This wake cycle issues no grant, so arbitration happens on the following IDLE cycle.
- Requesters hold req, rw, addr and wdata until grant. After grant, inputs are don't-care. Deasserting req mid-ACCESS does not abort the transaction.
- A req still high after done is re-arbitrated as a new request.
- Address ≥ MEM_DEPTH: a write is dropped; a read returns 0. done still pulses.

## Timing
- Latency from req sampled in IDLE to grant is 1 cycle. Latency from req to done is PROC_CYCLES cycles.
- Throughput is one access per PROC_CYCLES+1 cycles (ACCESS plus one IDLE arbitration cycle).
- With PROC_CYCLES=1, grant and done pulse in the same cycle.
- Back-to-back write then read to the same address returns the new data.
- Simultaneous requests are resolved round-robin. No port waits more than NUM_PORTS-1 transactions.
- Reset asserted mid-ACCESS aborts the access. No memory write occurs and no done pulse is issued.

## Configuration
- MPMC_LOW_POWER_EN defined: the idle counter and LOW_POWER state exist as described above.
- MPMC_LOW_POWER_EN not defined: the idle counter and LOW_POWER state are removed. low_power is tied to 0, and IDLE waits indefinitely.

## Structure
- Package mpmc_pkg holds:
  - the state enum (IDLE, ACCESS, LOW_POWER)
  - the RW_READ/RW_WRITE constants
  - a one-hot-to-index function
- Sub-module mpmc_rr_arbiter (parameter NUM_PORTS) takes req, an advance strobe and the last-grant pointer. It outputs a one-hot winner and the winner's index.

## Test plan
- Single write then read, port 0, addr 3, data 8'hA5, PROC_CYCLES=2 -> grant in cycle 1, done in cycle 2, read rdata=8'hA5.
- All 4 ports request continuously -> grants rotate 0,1,2,3,0 with one per 3 cycles.
- No requests for 10 cycles -> low_power=1. Then req[2] -> IDLE after 1 cycle, grant[2] 1 cycle later.
- Reset mid-write (port 1, addr 5, 8'h3C) -> later read of addr 5 returns 8'h00.
- MEM_DEPTH=12, write addr 14 -> done pulses, memory unchanged, read addr 14 returns 0.
- Build without MPMC_LOW_POWER_EN, idle 50 cycles -> low_power stays 0, next req granted 1 cycle after sampling.
